// File: rtl/apb_pkg.sv
// Shared APB master types and defaults; supplies fallback widths when the
// project-wide APB_ADDR_WIDTH / APB_DATA_WIDTH defines are not already set.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int APB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter. expired flags the wait cycle whose increment
// reaches TIMEOUT_CYCLES, so the master can abort on that same edge.
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_count;

    // Count wait cycles; cleared before each ACCESS phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (clr) begin
            r_count <= 8'd0;
        end else if (en) begin
            r_count <= r_count + 8'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign expired = en && (r_count == LAST_WAIT);

endmodule

// File: rtl/apb_master.sv
// Single-command APB master: IDLE -> SETUP -> ACCESS -> RESP with wait timeout.
// Optional slave-error support is enabled with macro APB_SLVERR_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = `APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = `APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready
`ifdef APB_SLVERR_EN
    ,
    input  logic                  pslverr
`endif
);

    apb_state_e            r_state;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  w_slv_err;
    logic                  w_cnt_clr;
    logic                  w_cnt_en;
    logic                  w_expired;

`ifdef APB_SLVERR_EN
    assign w_slv_err = pslverr;
`else
    assign w_slv_err = 1'b0;
`endif

    // The counter is armed in SETUP so it reads zero on the first ACCESS cycle.
    assign w_cnt_clr = (r_state == SETUP);
    assign w_cnt_en  = (r_state == ACCESS) && !pready;

    apb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_cnt_clr),
        .en     (w_cnt_en),
        .expired(w_expired)
    );

    // Transfer FSM with all bus and response outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {DATA_WIDTH{1'b0}};
            r_rsp_err   <= 1'b0;
            r_paddr     <= {ADDR_WIDTH{1'b0}};
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= {DATA_WIDTH{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_paddr     <= req_addr;
                        r_pwrite    <= req_write;
                        r_pwdata    <= req_wdata;
                        r_psel      <= 1'b1;
                        r_req_ready <= 1'b0;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pwrite ? {DATA_WIDTH{1'b0}} : prdata;
                        r_rsp_err   <= w_slv_err;
                        r_state     <= RESP;
                    end else if (w_expired) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= {DATA_WIDTH{1'b0}};
                        r_rsp_err   <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign paddr     = r_paddr;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master (TIMEOUT_CYCLES=4) with a response scoreboard.
// Slave-error scenarios are exercised when APB_SLVERR_EN is defined.
module tb_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = 32'h0;
    logic [DW-1:0] req_wdata = 32'h0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = 32'h0;
    logic          pready = 1'b0;
`ifdef APB_SLVERR_EN
    logic          pslverr = 1'b0;
`endif

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    apb_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
`ifdef APB_SLVERR_EN
        , .pslverr(pslverr)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a command in the current cycle, push its expected response, step into SETUP.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] exp_rd, input logic exp_err);
        exp_t e;
        int   guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        if (guard >= 20) begin
            n_total++;
            $display("FAIL issue_wait_ready: got req_ready=%b want 1", req_ready);
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        step();
        req_valid = 1'b0;
    endtask

    // Follow ACCESS cycles; slave answers on the ready_at-th cycle (0 = never).
    task automatic wait_access(input int ready_at, input logic [DW-1:0] data,
                               input logic [AW-1:0] a, output int n);
        bit done;
        done = 1'b0;
        n = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            step();
            if (!(psel === 1'b1 && penable === 1'b1)) begin
                done = 1'b1;
            end else begin
                n++;
                n_total++;
                if (paddr !== a) $display("FAIL access_paddr: got %h want %h", paddr, a);
                else n_pass++;
                pready = (ready_at != 0) && (n >= ready_at);
                prdata = pready ? data : 32'hBAD0_BAD0;
            end
        end
        if (!done) begin
            n_total++;
            $display("FAIL access_bound: got %0d cycles want exit", n);
        end
    endtask

    // Pop the scoreboard and compare against the presented response.
    task automatic collect_rsp(input string name);
        exp_t e;
        n_total++;
        if (rsp_valid !== 1'b1) $display("FAIL %s_rsp_valid: got %b want 1", name, rsp_valid);
        else n_pass++;
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL %s_scoreboard: got 0 entries want 1", name);
        end else begin
            n_pass++;
            e = sb.pop_front();
            n_total++;
            if (rsp_rdata !== e.rdata) $display("FAIL %s_rdata: got %h want %h", name, rsp_rdata, e.rdata);
            else n_pass++;
            n_total++;
            if (rsp_err !== e.err) $display("FAIL %s_err: got %b want %b", name, rsp_err, e.err);
            else n_pass++;
        end
    endtask

    // Hold rsp_ready low for hold cycles checking stability, then complete the handshake.
    task automatic finish_rsp(input int hold);
        logic [DW-1:0] d0;
        logic          e0;
        d0 = rsp_rdata;
        e0 = rsp_err;
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            step();
            n_total++;
            if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {1'b1, e0, d0, 1'b0})
                $display("FAIL rsp_hold: got v=%b e=%b d=%h rdy=%b want v=1 e=%b d=%h rdy=0",
                         rsp_valid, rsp_err, rsp_rdata, req_ready, e0, d0);
            else n_pass++;
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        pready    = 1'b0;
        n_total++;
        if ({rsp_valid, req_ready} !== 2'b01)
            $display("FAIL rsp_release: got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_total++;
        if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b00000)
            $display("FAIL reset_ctrl: got %b want 00000", {psel, penable, pwrite, rsp_valid, rsp_err});
        else n_pass++;
        n_total++;
        if ({paddr, pwdata, rsp_rdata} !== 96'h0)
            $display("FAIL reset_data: got %h want 0", {paddr, pwdata, rsp_rdata});
        else n_pass++;
        rst = 1'b0;
        step();
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_write_zero_wait();
        pready = 1'b1;
        prdata = 32'hFFFF_0000;
        issue(1'b1, 32'h10, 32'hA5A5_A5A5, 32'h0, 1'b0);
        n_total++;
        if ({psel, penable, pwrite, req_ready} !== 4'b1010)
            $display("FAIL write_setup: got %b want 1010", {psel, penable, pwrite, req_ready});
        else n_pass++;
        n_total++;
        if ({paddr, pwdata} !== {32'h10, 32'hA5A5_A5A5})
            $display("FAIL write_setup_bus: got %h/%h want 10/a5a5a5a5", paddr, pwdata);
        else n_pass++;
        step();
        n_total++;
        if ({psel, penable, rsp_valid} !== 3'b110)
            $display("FAIL write_access: got %b want 110", {psel, penable, rsp_valid});
        else n_pass++;
        step();
        n_total++;
        if ({psel, penable} !== 2'b00) $display("FAIL write_resp_bus: got %b want 00", {psel, penable});
        else n_pass++;
        collect_rsp("write");
        finish_rsp(0);
    endtask

    task automatic test_read_wait_states();
        int n;
        pready = 1'b0;
        issue(1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0);
        wait_access(4, 32'h1234_5678, 32'h20, n);
        n_total++;
        if (n !== 4) $display("FAIL read_wait_len: got %0d want 4", n);
        else n_pass++;
        collect_rsp("read_wait");
        finish_rsp(0);
    endtask

    task automatic test_timeout();
        int n;
        pready = 1'b0;
        issue(1'b0, 32'h30, 32'h0, 32'h0, 1'b1);
        wait_access(0, 32'hCAFE_CAFE, 32'h30, n);
        n_total++;
        if (n !== 4) $display("FAIL timeout_len: got %0d want 4", n);
        else n_pass++;
        n_total++;
        if ({psel, penable} !== 2'b00) $display("FAIL timeout_bus: got %b want 00", {psel, penable});
        else n_pass++;
        collect_rsp("timeout");
        finish_rsp(0);
    endtask

    task automatic test_err_backpressure();
        int n;
`ifdef APB_SLVERR_EN
        pslverr = 1'b1;
        issue(1'b0, 32'h60, 32'h0, 32'h0000_DEAD, 1'b1);
`else
        issue(1'b0, 32'h60, 32'h0, 32'h0000_DEAD, 1'b0);
`endif
        wait_access(1, 32'h0000_DEAD, 32'h60, n);
`ifdef APB_SLVERR_EN
        pslverr = 1'b0;
`endif
        collect_rsp("backpressure");
        finish_rsp(5);
    endtask

    task automatic test_reset_mid_access();
        int n;
        pready = 1'b0;
        issue(1'b1, 32'h40, 32'h0BAD_F00D, 32'h0, 1'b0);
        step();
        n_total++;
        if ({psel, penable} !== 2'b11) $display("FAIL midrst_access: got %b want 11", {psel, penable});
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(sb.pop_back());
        n_total++;
        if ({psel, penable, rsp_valid, req_ready} !== 4'b0001)
            $display("FAIL midrst_state: got %b want 0001", {psel, penable, rsp_valid, req_ready});
        else n_pass++;
        issue(1'b0, 32'h44, 32'h0, 32'h0000_55AA, 1'b0);
        wait_access(2, 32'h0000_55AA, 32'h44, n);
        n_total++;
        if (n !== 2) $display("FAIL midrst_after_len: got %0d want 2", n);
        else n_pass++;
        collect_rsp("after_reset");
        finish_rsp(0);
    endtask

    task automatic test_back_to_back();
        int   n;
        exp_t e;
        issue(1'b1, 32'h50, 32'h1111_1111, 32'h0, 1'b0);
        wait_access(1, 32'h0000_0077, 32'h50, n);
        collect_rsp("b2b_first");
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h54;
        e.rdata = 32'h9999_0000;
        e.err   = 1'b0;
        sb.push_back(e);
        step();
        rsp_ready = 1'b0;
        n_total++;
        if ({rsp_valid, req_ready, psel} !== 3'b010)
            $display("FAIL b2b_gap: got %b want 010", {rsp_valid, req_ready, psel});
        else n_pass++;
        step();
        req_valid = 1'b0;
        n_total++;
        if ({psel, penable, req_ready} !== 3'b100 || paddr !== 32'h54)
            $display("FAIL b2b_setup: got %b/%h want 100/54", {psel, penable, req_ready}, paddr);
        else n_pass++;
        wait_access(1, 32'h9999_0000, 32'h54, n);
        collect_rsp("b2b_second");
        finish_rsp(0);
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait_states();
        test_timeout();
        test_err_backpressure();
        test_reset_mid_access();
        test_back_to_back();
        n_total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default `APB_ADDR_WIDTH, sets the address width.
REQ-002 Parameter DATA_WIDTH, default `APB_DATA_WIDTH, sets the data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, sets the maximum number of ACCESS-phase wait cycles; legal range 1..255.
REQ-004 Ports SHALL be exactly:
clk  in  1  single clock; all logic rising-edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  command present
req_ready  out  1  command accepted when high with req_valid
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  target address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data
rsp_err  out  1  error response (slave error or timeout)
paddr  out  ADDR_WIDTH  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error (present only with APB_SLVERR_EN)

Function
REQ-005 The FSM SHALL have states IDLE, SETUP, ACCESS and RESP; all outputs SHALL be registered.
REQ-006 req_ready SHALL be 1 only in IDLE; on req_valid&&req_ready, the command fields SHALL be latched and the FSM SHALL go to SETUP.
REQ-007 SETUP SHALL last exactly one cycle with psel=1, penable=0 and paddr/pwrite/pwdata = latched values, then go to ACCESS.
REQ-008 ACCESS SHALL drive psel=1 and penable=1, with paddr/pwrite/pwdata held stable, until pready=1 or timeout.
REQ-009 On pready=1 in ACCESS, the block SHALL capture prdata (zero for writes) into rsp_rdata, deassert psel and penable next cycle, and go to RESP.
REQ-010 A wait counter SHALL clear on entering ACCESS and increment for each ACCESS cycle with pready=0.
REQ-011 When the counter reaches TIMEOUT_CYCLES, the block SHALL abort: psel=0, penable=0, rsp_err=1, rsp_rdata=0, and go to RESP.
REQ-012 RESP SHALL hold rsp_valid=1 and stable data until rsp_ready=1, then go to IDLE; back-to-back commands therefore start no earlier than the cycle after the handshake.
REQ-013 Minimum latency: command accepted in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3 if pready=1 in cycle 2.
REQ-014 pready and prdata SHALL be ignored outside ACCESS.

Reset
REQ-015 While rst=1, the FSM SHALL go to IDLE and psel, penable, pwrite, rsp_valid, rsp_err, paddr, pwdata and rsp_rdata SHALL be 0; req_ready SHALL be 1 from the first cycle after reset.
REQ-016 Reset in SETUP, ACCESS or RESP SHALL abandon the transfer without producing a response.

Configuration
REQ-017 With macro APB_SLVERR_EN defined, port pslverr SHALL exist and, when sampled with pready=1 in ACCESS, SHALL set rsp_err=1 while still returning prdata.
REQ-018 Without APB_SLVERR_EN, port pslverr SHALL be absent and rsp_err SHALL assert only on timeout.

Structure
REQ-019 A shared package apb_pkg SHALL hold the state enum apb_state_e and the default timeout constant; widths SHALL come from the existing `APB_ADDR_WIDTH/`APB_DATA_WIDTH defines.
REQ-020 The wait counter SHALL be a sub-module, apb_timeout_cnt, with ports clr, en and expired.

Verification
REQ-021 Write addr 0x10, data 0xA5A5A5A5, pready=1 immediately -> psel in cycle 1, penable in cycle 2, rsp_valid in cycle 3, rsp_err=0.
REQ-022 Read addr 0x20, slave inserts 3 wait states, prdata=0x12345678 -> ACCESS lasts 4 cycles with paddr stable, rsp_rdata=0x12345678.
REQ-023 TIMEOUT_CYCLES=4, pready held 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0, psel=0 next cycle.
REQ-024 APB_SLVERR_EN defined, read with pslverr=1 and prdata=0xDEAD -> rsp_err=1, rsp_rdata=0xDEAD; rsp_ready held 0 for 5 cycles -> response stable, req_ready=0.
REQ-025 rst=1 asserted mid-ACCESS -> next cycle psel=0, penable=0, rsp_valid=0, req_ready=1; the following command completes normally.
